// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - Client-side and memory-side bus bundle for mem_bus_arbiter
interface mem_bus_arbiter_if #(
  parameter int N_CLIENTS       = 4,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  // Client request side (packed per client: client i at [i*W +: W])
  logic [N_CLIENTS-1:0]        cl_req_valid;
  logic [N_CLIENTS-1:0]        cl_req_ready;
  logic [N_CLIENTS-1:0]        cl_req_write;
  logic [N_CLIENTS*ADDR_W-1:0] cl_req_addr;
  logic [N_CLIENTS*DATA_W-1:0] cl_req_wdata;

  // Client response side (data broadcast, strobe one-hot)
  logic [N_CLIENTS-1:0]        cl_rsp_valid;
  logic [DATA_W-1:0]           cl_rsp_rdata;

  // Shared memory side
  logic                        mem_req_valid;
  logic                        mem_req_ready;
  logic                        mem_req_write;
  logic [ADDR_W-1:0]           mem_req_addr;
  logic [DATA_W-1:0]           mem_req_wdata;
  logic                        mem_rsp_valid;
  logic [DATA_W-1:0]           mem_rsp_rdata;

  // Status
  logic [CNT_W-1:0]            outstanding;
  logic                        err_unexpected_rsp;

  // Arbiter view
  modport slave (
    input  cl_req_valid, cl_req_write, cl_req_addr, cl_req_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    output cl_req_ready, cl_rsp_valid, cl_rsp_rdata,
    output mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
    output outstanding, err_unexpected_rsp
  );

  // Harness view (clients plus memory model)
  modport master (
    output cl_req_valid, cl_req_write, cl_req_addr, cl_req_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    input  cl_req_ready, cl_rsp_valid, cl_rsp_rdata,
    input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
    input  outstanding, err_unexpected_rsp
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - Round-robin N-client memory arbiter with in-order response routing
module mem_bus_arbiter #(
  parameter int N_CLIENTS       = 4,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_bus_arbiter_if.slave  bus
);
  localparam int IDX_W = $clog2(N_CLIENTS);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_CLIENTS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTSTANDING);

  // Arbitration and ID FIFO state
  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] id_mem_q [MAX_OUTSTANDING];
  logic [IDX_W-1:0] id_mem_d [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] head;
  logic             found;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  // Round-robin search starting just after the last granted client; with no
  // valid requester the winner defaults to last+1 so the mux stays defined.
  always_comb begin
    found  = 1'b0;
    winner = IDX_W'((int'(last_q) + 1) % N_CLIENTS);
    for (int k = 1; k <= N_CLIENTS; k++) begin
      if (!found && bus.cl_req_valid[(int'(last_q) + k) % N_CLIENTS]) begin
        found  = 1'b1;
        winner = IDX_W'((int'(last_q) + k) % N_CLIENTS);
      end
    end
  end

  assign fifo_full  = (count_q == CNT_FULL);
  assign fifo_empty = (count_q == '0);
  assign head       = id_mem_q[rd_ptr_q];

  // A full FIFO blocks the grant even if a pop frees a slot this cycle.
  assign bus.mem_req_valid = found && !fifo_full;
  assign bus.mem_req_write = bus.cl_req_write[winner];
  assign bus.mem_req_addr  = bus.cl_req_addr[int'(winner)*ADDR_W +: ADDR_W];
  assign bus.mem_req_wdata = bus.cl_req_wdata[int'(winner)*DATA_W +: DATA_W];

  assign push = bus.mem_req_valid && bus.mem_req_ready;
  assign pop  = bus.mem_rsp_valid && !fifo_empty;

  assign bus.cl_req_ready = push ? (N_CLIENTS'(1) << winner) : '0;
  assign bus.cl_rsp_valid = pop  ? (N_CLIENTS'(1) << head)   : '0;
  assign bus.cl_rsp_rdata = bus.mem_rsp_rdata;

  assign bus.outstanding        = count_q;
  assign bus.err_unexpected_rsp = err_q;

  // Next-state for pointer, FIFO, counter and the sticky spurious-response flag
  always_comb begin
    last_d   = last_q;
    id_mem_d = id_mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    err_d    = err_q;
    if (push) begin
      id_mem_d[wr_ptr_q] = winner;
      wr_ptr_d           = wr_ptr_q + PTR_W'(1);
      last_d             = winner;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (bus.mem_rsp_valid && fifo_empty) begin
      err_d = 1'b1;
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // State registers; reset gives client 0 first priority and drops in-flight IDs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q   <= LAST_RST;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        id_mem_q[i] <= '0;
      end
    end else begin
      last_q   <= last_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      id_mem_q <= id_mem_d;
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - Randomized self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.N_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MO)) bus ();

  mem_bus_arbiter #(.N_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    int            cli;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            acc;
  } txn_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state
  int            rr_last;
  bit            err_exp;
  txn_t          inflight[$];
  bit            act[N];
  bit            req_wr[N];
  logic [AW-1:0] req_addr[N];
  logic [DW-1:0] req_wdata[N];
  logic [DW-1:0] mem_arr[16];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic drive_clients();
    for (int i = 0; i < N; i++) begin
      bus.cl_req_valid[i]            = act[i];
      bus.cl_req_write[i]            = req_wr[i];
      bus.cl_req_addr[i*AW +: AW]    = req_addr[i];
      bus.cl_req_wdata[i*DW +: DW]   = req_wdata[i];
    end
  endtask

  // One clock cycle: drive at posedge+1, check at negedge, advance model, return at posedge+1
  task automatic step(input int p_req, input int p_rdy, input int p_rsp, input bit force_rsp);
    bit            rdy, rsp, hs, exp_valid;
    int            win;
    logic [DW-1:0] rdata;
    logic [N-1:0]  exp_ready, exp_rsp;
    txn_t          t;
    for (int i = 0; i < N; i++) begin
      if (!act[i] && int'($urandom_range(99)) < p_req) begin
        act[i]       = 1'b1;
        req_wr[i]    = 1'($urandom_range(1));
        req_addr[i]  = AW'($urandom_range(15) * 4);
        req_wdata[i] = $urandom;
      end
    end
    drive_clients();
    rdy   = int'($urandom_range(99)) < p_rdy;
    rsp   = force_rsp || (inflight.size() > 0 && inflight[0].acc < cyc &&
                          int'($urandom_range(99)) < p_rsp);
    rdata = $urandom;
    if (rsp && inflight.size() > 0) begin
      t = inflight[0];
      if (t.wr) mem_arr[t.addr[5:2]] = t.wdata;
      else      rdata = mem_arr[t.addr[5:2]];
    end
    bus.mem_req_ready = rdy;
    bus.mem_rsp_valid = rsp;
    bus.mem_rsp_rdata = rdata;
    @(negedge clk);
    win = -1;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (rr_last + k) % N;
      if (act[c] && win < 0) win = c;
    end
    exp_valid = (win >= 0) && (inflight.size() < MO);
    hs        = exp_valid && rdy;
    exp_ready = hs ? (N'(1) << win) : '0;
    exp_rsp   = (rsp && inflight.size() > 0) ? (N'(1) << inflight[0].cli) : '0;
    check("mem_req_valid", 64'(bus.mem_req_valid), 64'(exp_valid));
    check("cl_req_ready", 64'(bus.cl_req_ready), 64'(exp_ready));
    if (exp_valid) begin
      check("mem_req_write", 64'(bus.mem_req_write), 64'(req_wr[win]));
      check("mem_req_addr", 64'(bus.mem_req_addr), 64'(req_addr[win]));
      check("mem_req_wdata", 64'(bus.mem_req_wdata), 64'(req_wdata[win]));
    end
    check("cl_rsp_valid", 64'(bus.cl_rsp_valid), 64'(exp_rsp));
    if (rsp) check("cl_rsp_rdata", 64'(bus.cl_rsp_rdata), 64'(rdata));
    check("outstanding", 64'(bus.outstanding), 64'(inflight.size()));
    check("err_flag", 64'(bus.err_unexpected_rsp), 64'(err_exp));
    if (rsp) begin
      if (inflight.size() > 0) void'(inflight.pop_front());
      else err_exp = 1'b1;
    end
    if (hs) begin
      t.cli   = win;
      t.wr    = req_wr[win];
      t.addr  = req_addr[win];
      t.wdata = req_wdata[win];
      t.acc   = cyc;
      inflight.push_back(t);
      rr_last  = win;
      act[win] = 1'b0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int n = 0; n < 64 && (inflight.size() > 0 || act[0] || act[1] || act[2] || act[3]); n++)
      step(0, 100, 100, 1'b0);
    check("drain_outstanding", 64'(bus.outstanding), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n             = 1'b0;
    rr_last           = N - 1;
    err_exp           = 1'b0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_rdata = '0;
    for (int i = 0; i < N; i++) begin
      act[i]       = 1'b0;
      req_wr[i]    = 1'b0;
      req_addr[i]  = AW'(32'h1000 * (i + 1) + 32'h230);
      req_wdata[i] = DW'(i);
    end
    for (int i = 0; i < 16; i++) mem_arr[i] = $urandom;
    drive_clients();
    repeat (3) @(negedge clk);
    check("rst_outstanding", 64'(bus.outstanding), 64'(0));
    check("rst_err", 64'(bus.err_unexpected_rsp), 64'(0));
    check("rst_mem_req_valid", 64'(bus.mem_req_valid), 64'(0));
    check("rst_cl_req_ready", 64'(bus.cl_req_ready), 64'(0));
    check("rst_cl_rsp_valid", 64'(bus.cl_rsp_valid), 64'(0));
    check("rst_mem_req_addr", 64'(bus.mem_req_addr), 64'(32'h1230));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single client read: client 2 reads 0x100, response one cycle later
    mem_arr[0]  = 32'hDEADBEEF;
    act[2]      = 1'b1;
    req_wr[2]   = 1'b0;
    req_addr[2] = 32'h100;
    step(0, 100, 0, 1'b0);
    check("single_outstanding", 64'(bus.outstanding), 64'(1));
    step(0, 100, 100, 1'b0);
    check("single_done", 64'(bus.outstanding), 64'(0));

    // Randomized phases: light, saturated, backpressure, responses withheld
    repeat (250) step(30, 80, 60, 1'b0);
    repeat (250) step(100, 100, 50, 1'b0);
    repeat (250) step(60, 20, 70, 1'b0);
    repeat (250) step(100, 100, 5, 1'b0);
    drain();

    // Spurious response with nothing in flight
    step(0, 0, 0, 1'b1);
    repeat (3) step(0, 0, 0, 1'b0);
    check("err_sticky", 64'(bus.err_unexpected_rsp), 64'(1));

    // Asynchronous reset with three requests in flight
    act[0] = 1'b1;
    act[1] = 1'b1;
    act[2] = 1'b1;
    repeat (3) step(0, 100, 0, 1'b0);
    check("pre_reset_outstanding", 64'(bus.outstanding), 64'(3));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_outstanding", 64'(bus.outstanding), 64'(0));
    check("async_rst_err", 64'(bus.err_unexpected_rsp), 64'(0));
    inflight.delete();
    err_exp = 1'b0;
    rr_last = N - 1;
    for (int i = 0; i < N; i++) act[i] = 1'b0;
    drive_clients();
    bus.mem_rsp_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    repeat (250) step(70, 60, 40, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Parametrised N-client memory-bus arbiter placed between several cache instances and a single shared memory model. It replaces the fixed one-cache/one-memory pairing in the top-level harness. Each client issues read/write requests on a valid/ready handshake. The arbiter grants one request per cycle in round-robin order, forwards it to memory, and routes the in-order memory responses back to the issuing client through an ID FIFO.

## Interface
Parameters:
- N_CLIENTS, 4: number of client ports (2..16).
- ADDR_W, 32: request address width.
- DATA_W, 32: data width.
- MAX_OUTSTANDING, 4: depth of the ID FIFO, i.e. maximum requests accepted by memory but not yet answered (power of two, ≥2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cl_req_valid  in  N_CLIENTS  per-client request valid.
- cl_req_ready  out  N_CLIENTS  per-client request accepted this cycle.
- cl_req_write  in  N_CLIENTS  per-client 1 = write, 0 = read.
- cl_req_addr  in  N_CLIENTS*ADDR_W  per-client address; client i occupies bits [i*ADDR_W +: ADDR_W].
- cl_req_wdata  in  N_CLIENTS*DATA_W  per-client write data; same packing rule.
- cl_rsp_valid  out  N_CLIENTS  one-hot response strobe.
- cl_rsp_rdata  out  DATA_W  response data, broadcast to all clients.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_write  out  1  forwarded write flag.
- mem_req_addr  out  ADDR_W  forwarded address.
- mem_req_wdata  out  DATA_W  forwarded write data.
- mem_rsp_valid  in  1  memory response, one per accepted request, in order.
- mem_rsp_rdata  in  DATA_W  response data (don't-care for writes).
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  number of requests in flight.
- err_unexpected_rsp  out  1  sticky: a response arrived with no request in flight.

## Operation
- Round-robin pointer `last` (index of the last granted client). Search order is last+1, last+2, … wrapping modulo N_CLIENTS. The winner is the first client in that order with cl_req_valid set.
- Grant is combinational from current valids and state.
  - mem_req_valid = (any cl_req_valid) && !fifo_full.
  - mem_req_* muxed from the winner.
  - cl_req_ready[i] = (i == winner) && mem_req_valid && mem_req_ready. At most one bit is set.
- Handshake (mem_req_valid && mem_req_ready):
  - push winner index into the ID FIFO;
  - `last` <= winner;
  - outstanding += 1.
- Non-granted clients must hold valid/addr/data stable. The arbiter does not latch their requests.
- Response (mem_rsp_valid): pop the FIFO head.
  - cl_rsp_valid[head] = 1 in the same cycle.
  - cl_rsp_rdata = mem_rsp_rdata (combinational pass-through).
  - outstanding -= 1.
- Every request, read or write, receives exactly one response.
- Simultaneous push and pop in one cycle: FIFO occupancy is unchanged; outstanding is unchanged.
- Full (outstanding == MAX_OUTSTANDING): no grant, even if a pop occurs in the same cycle. Grant resumes the following cycle.
- Empty with mem_rsp_valid: no cl_rsp_valid bit asserted. err_unexpected_rsp is set and holds until reset. FIFO and counter remain at 0; no underflow.
- FIFO pointers are log2(MAX_OUTSTANDING) bits and wrap naturally. A separate count disambiguates full from empty.

## Timing
- Reset (rst_n low, takes effect immediately):
  - last = N_CLIENTS-1, so client 0 has first priority;
  - FIFO empty; outstanding = 0; err_unexpected_rsp = 0.
  - Consequently cl_req_ready = 0, cl_rsp_valid = 0, mem_req_valid = 0 (no valids in reset by harness rule), mem_req_* = client-0 fields.
- Reset asserted mid-operation discards all in-flight IDs. Responses arriving after reset are flagged by err_unexpected_rsp. The harness must drain memory before releasing reset.
- Request path is zero latency: client valid to mem_req_valid in the same cycle.
- Sustained throughput is one grant per cycle while not full.
- Response path is zero latency: mem_rsp_valid to cl_rsp_valid in the same cycle.
- A request accepted at edge k may receive its response at edge k+1 at the earliest. A response in the same cycle as its own acceptance is illegal.

## Test plan
- Reset then single client: client 2 reads 0x100 while memory always ready and returns data 0xDEADBEEF one cycle later -> cl_req_ready = 0b0100 for one cycle; next cycle cl_rsp_valid = 0b0100 with rdata 0xDEADBEEF; outstanding goes 0→1→0.
- Fairness: all 4 clients hold valid continuously, memory always ready -> grant order 0,1,2,3,0,1,… (each client once per 4 cycles); responses return with matching one-hot order.
- Backpressure: mem_req_ready low for 5 cycles with clients 1 and 3 valid -> no cl_req_ready during the stall; on release client 1 is granted first, then client 3; request fields stable throughout.
- Full FIFO: memory withholds responses, MAX_OUTSTANDING = 4 -> exactly 4 grants, then mem_req_valid = 0. A response arriving in the full cycle produces no grant that cycle and one grant the next cycle.
- Mixed write/read ordering: client 0 writes 0x55 to 0x40, client 1 reads 0x40 -> write acked to client 0 before client 1 receives 0x55.
- Spurious response with empty FIFO -> all cl_rsp_valid remain 0, err_unexpected_rsp rises and stays 1. Asynchronous reset mid-burst with 3 outstanding -> outstanding = 0 and flag = 0 immediately, without waiting for a clock edge.
